// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch command path.
// Holds the inc-button repeat FSM states, counter width and default timing.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rep_state_t;

    localparam int unsigned MS_CNT_W      = 10;
    localparam int unsigned HOLD_MS_DEF   = 500;
    localparam int unsigned REPEAT_MS_DEF = 100;

endpackage : stopwatch_pkg

// File: rtl/btn_repeat.sv
// One increment-button channel: press edge, hold delay, then periodic auto-repeat.
// Emits a one-cycle pulse per press and per repeat interval.
module btn_repeat
    import stopwatch_pkg::*;
#(
    parameter int unsigned HOLD_MS   = HOLD_MS_DEF,
    parameter int unsigned REPEAT_MS = REPEAT_MS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ms_tick,
    input  logic lvl,
    output logic pulse,
    output logic rep
);

    localparam logic [MS_CNT_W-1:0] HOLD_CNT   = MS_CNT_W'(HOLD_MS);
    localparam logic [MS_CNT_W-1:0] REPEAT_CNT = MS_CNT_W'(REPEAT_MS);

    rep_state_t          state_q;
    rep_state_t          state_d;
    logic [MS_CNT_W-1:0] cnt_q;
    logic [MS_CNT_W-1:0] cnt_d;
    logic [MS_CNT_W-1:0] cnt_inc;
    logic                lvl_q;
    logic                rise;
    logic                pulse_d;

    assign rise    = lvl & ~lvl_q;
    assign cnt_inc = cnt_q + MS_CNT_W'(1);

    // State, counter and output registers; lvl_q resets high so a held button gives no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b1;
            pulse   <= 1'b0;
            rep     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl;
            pulse   <= pulse_d;
            rep     <= (state_d == REPEAT);
        end
    end

    // Next state; a release always wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!lvl) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (ms_tick) begin
                        if (cnt_inc == HOLD_CNT) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                            state_d = REPEAT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                REPEAT: begin
                    if (!lvl) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (ms_tick) begin
                        if (cnt_inc == REPEAT_CNT) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule : btn_repeat

// File: rtl/button_event_gen.sv
// Turns debounced button/switch levels into one-cycle timer command strobes.
// Start/stop/softrst strobe once per press; the inc buttons auto-repeat while held.
module button_event_gen
    import stopwatch_pkg::*;
#(
    parameter int unsigned HOLD_MS   = HOLD_MS_DEF,
    parameter int unsigned REPEAT_MS = REPEAT_MS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clk1k,
    input  logic en,
    input  logic start_lvl,
    input  logic stop_lvl,
    input  logic softrst_lvl,
    input  logic inc_min_lvl,
    input  logic inc_sec_lvl,
    output logic start,
    output logic stop,
    output logic softrst,
    output logic inc_min,
    output logic inc_sec,
    output logic repeating
);

    logic clk1k_q;
    logic start_q;
    logic stop_q;
    logic softrst_q;
    logic ms_tick_c;
    logic start_rise;
    logic stop_rise;
    logic softrst_rise;
    logic rep_min;
    logic rep_sec;

    assign ms_tick_c    = clk1k & ~clk1k_q;
    assign start_rise   = start_lvl & ~start_q;
    assign stop_rise    = stop_lvl & ~stop_q;
    assign softrst_rise = softrst_lvl & ~softrst_q;

    // Edge history keeps tracking while disabled; stop takes priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk1k_q   <= 1'b0;
            start_q   <= 1'b1;
            stop_q    <= 1'b1;
            softrst_q <= 1'b1;
            start     <= 1'b0;
            stop      <= 1'b0;
            softrst   <= 1'b0;
            repeating <= 1'b0;
        end else begin
            clk1k_q   <= clk1k;
            start_q   <= start_lvl;
            stop_q    <= stop_lvl;
            softrst_q <= softrst_lvl;
            start     <= en & start_rise & ~stop_rise;
            stop      <= en & stop_rise;
            softrst   <= en & softrst_rise;
            repeating <= rep_min | rep_sec;
        end
    end

    btn_repeat #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS)
    ) u_inc_min (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ms_tick (ms_tick_c),
        .lvl     (inc_min_lvl),
        .pulse   (inc_min),
        .rep     (rep_min)
    );

    btn_repeat #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS)
    ) u_inc_sec (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ms_tick (ms_tick_c),
        .lvl     (inc_sec_lvl),
        .pulse   (inc_sec),
        .rep     (rep_sec)
    );

endmodule : button_event_gen
